// File: rtl/seven_seg_scan_if.sv
// Display bus between the game logic and the seven-segment scanner.
// The master drives the digit values and enables, and the slave drives the board pins.
interface seven_seg_scan_if;
  logic       digit0_en_i;
  logic       digit1_en_i;
  logic       digit2_en_i;
  logic       digit3_en_i;
  logic [3:0] digit0_i;
  logic [3:0] digit1_i;
  logic [3:0] digit2_i;
  logic [3:0] digit3_i;
  logic [3:0] dp_i;
  logic [3:0] anode_o;
  logic [6:0] segments_o;
  logic       dp_o;
  logic       frame_o;

  modport master (
    output digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i,
    output digit0_i, digit1_i, digit2_i, digit3_i, dp_i,
    input  anode_o, segments_o, dp_o, frame_o
  );

  modport slave (
    input  digit0_en_i, digit1_en_i, digit2_en_i, digit3_en_i,
    input  digit0_i, digit1_i, digit2_i, digit3_i, dp_i,
    output anode_o, segments_o, dp_o, frame_o
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit seven-segment driver with a per-frame input snapshot
// and an anode-off guard at every digit switch. All pins are active-low except frame_o.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  seven_seg_scan_if.slave   bus
);
  localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] slot_to_anode(input logic [1:0] slot);
    logic [3:0] anode;
    case (slot)
      2'd0:    anode = 4'hE;
      2'd1:    anode = 4'hD;
      2'd2:    anode = 4'hB;
      2'd3:    anode = 4'h7;
      default: anode = 4'hF;
    endcase
    return anode;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [1:0]       slot_r;
  logic [1:0]       slot_next_s;
  logic [3:0]       en_r;
  logic [3:0][3:0]  digit_r;
  logic [3:0]       dp_r;
  logic [3:0]       en_in_s;
  logic [3:0][3:0]  digit_in_s;
  logic             snap_s;
  logic [3:0]       anode_s;
  logic [6:0]       seg_s;
  logic             dp_s;
  logic [3:0]       anode_r;
  logic [6:0]       seg_r;
  logic             dp_r_out;
  logic             frame_r;

  assign en_in_s    = {bus.digit3_en_i, bus.digit2_en_i, bus.digit1_en_i, bus.digit0_en_i};
  assign digit_in_s = {bus.digit3_i, bus.digit2_i, bus.digit1_i, bus.digit0_i};
  assign snap_s     = (cnt_r == CNT_ZERO) && (slot_r == 2'd0);

  // Slot counter wrap and slot advance.
  always_comb begin
    cnt_next_s  = cnt_r + CNT_ONE;
    slot_next_s = slot_r;
    if (cnt_r == CNT_LAST) begin
      cnt_next_s  = CNT_ZERO;
      slot_next_s = slot_r + 2'd1;
    end else begin
      cnt_next_s  = cnt_r + CNT_ONE;
      slot_next_s = slot_r;
    end
  end

  // Pin values for the next cycle: lit only in the drive phase of an enabled digit.
  always_comb begin
    anode_s = 4'hF;
    seg_s   = 7'h7F;
    dp_s    = 1'b1;
    if ((cnt_r >= CNT_BLANK) && en_r[slot_r]) begin
      anode_s = slot_to_anode(slot_r);
      seg_s   = hex_to_seg(digit_r[slot_r]);
      dp_s    = ~dp_r[slot_r];
    end else begin
      anode_s = 4'hF;
      seg_s   = 7'h7F;
      dp_s    = 1'b1;
    end
  end

  // Scan state, frame snapshot and registered pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r    <= CNT_ZERO;
      slot_r   <= 2'd0;
      en_r     <= 4'h0;
      digit_r  <= {4{4'h0}};
      dp_r     <= 4'h0;
      anode_r  <= 4'hF;
      seg_r    <= 7'h7F;
      dp_r_out <= 1'b1;
      frame_r  <= 1'b1;
    end else begin
      cnt_r    <= cnt_next_s;
      slot_r   <= slot_next_s;
      anode_r  <= anode_s;
      seg_r    <= seg_s;
      dp_r_out <= dp_s;
      // frame_r tracks the state being entered, so it is high exactly when cnt/slot are 0.
      frame_r  <= (cnt_next_s == CNT_ZERO) && (slot_next_s == 2'd0);
      if (snap_s) begin
        en_r    <= en_in_s;
        digit_r <= digit_in_s;
        dp_r    <= bus.dp_i;
      end else begin
        en_r    <= en_r;
        digit_r <= digit_r;
        dp_r    <= dp_r;
      end
    end
  end

  assign bus.anode_o    = anode_r;
  assign bus.segments_o = seg_r;
  assign bus.dp_o       = dp_r_out;
  assign bus.frame_o    = frame_r;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a cycle-indexed reference model
// that derives slot, phase and snapshot purely from the cycle number since reset.
module tb_seven_seg_scan;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seven_seg_scan_if bus();

  seven_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // model state
  int         mcnt = 0;
  logic       sh_en  [4];
  logic [3:0] sh_dig [4];
  logic       sh_dp  [4];
  logic       exp_valid = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic       exp_fr;

  int scen = 0;
  int rst_left = 0;
  int anode_d_seen = 0;
  logic rst_pending_chk = 1'b0;
  logic scen6_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d (scenario %0d): got %h expected %h", tag, mcnt, scen, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic [3:0] en, input logic [3:0] dp);
    bus.digit3_i = d3; bus.digit2_i = d2; bus.digit1_i = d1; bus.digit0_i = d0;
    bus.digit3_en_i = en[3]; bus.digit2_en_i = en[2];
    bus.digit1_en_i = en[1]; bus.digit0_en_i = en[0];
    bus.dp_i = dp;
  endtask

  task automatic apply_stim();
    if (scen == 6 && mcnt == 20 && !scen6_done && rst_left == 0) begin
      rst_left = 1;
      scen6_done = 1'b1;
      rst_pending_chk = 1'b1;
    end
    if (scen == 5 && rst_left == 0 && $urandom_range(0, 79) == 0) rst_left = 1;
    if (rst_left > 0) begin
      rst = 1'b1;
      rst_left--;
      if (scen != 6) set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      return;
    end
    rst = 1'b0;
    case (scen)
      1, 6: set_inputs(4'hF, 4'hA, 4'h8, 4'h1, 4'hF, 4'h0);
      2: set_inputs($urandom, $urandom, 4'h0, $urandom, 4'b1101, $urandom);
      3: set_inputs(4'h3, 4'h7, 4'hC, (mcnt < 10) ? 4'h5 : 4'h9, 4'hF, 4'h0);
      4: set_inputs($urandom, $urandom, $urandom, $urandom, 4'hF, 4'b0100);
      default: set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    endcase
  endtask

  task automatic tick();
    int c, s, zeros;
    @(negedge clk);
    if (exp_valid) begin
      check_eq("anode", bus.anode_o, exp_an);
      check_eq("segments", bus.segments_o, exp_seg);
      check_eq("dp", bus.dp_o, exp_dp);
      check_eq("frame", bus.frame_o, exp_fr);
      zeros = 0;
      for (int k = 0; k < 4; k++) if (bus.anode_o[k] == 1'b0) zeros++;
      check_eq("anode_at_most_one_low", (zeros <= 1), 1);
      if (scen == 2 && bus.anode_o == 4'hD) anode_d_seen++;
      if (scen == 1 && mcnt == 9) check_eq("scan_gap_blank", bus.anode_o, 4'hF);
      if (scen == 1 && mcnt == 12) begin
        check_eq("scan_slot1_anode", bus.anode_o, 4'hD);
        check_eq("scan_slot1_seg", bus.segments_o, 7'h00);
      end
      if (scen == 3 && mcnt == 5) check_eq("midframe_old", bus.segments_o, 7'h12);
      if (scen == 3 && mcnt == 37) check_eq("midframe_new", bus.segments_o, 7'h10);
      if (scen == 4 && bus.anode_o != 4'hB) check_eq("dp_only_slot2", bus.dp_o, 1'b1);
      if (rst_pending_chk) begin
        check_eq("midrst_anode", bus.anode_o, 4'hF);
        check_eq("midrst_frame", bus.frame_o, 1'b1);
        rst_pending_chk = 1'b0;
      end
    end
    apply_stim();
    if (rst) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fr = 1'b1;
      for (int k = 0; k < 4; k++) begin
        sh_en[k] = 1'b0; sh_dig[k] = 4'h0; sh_dp[k] = 1'b0;
      end
      mcnt = 0;
    end else begin
      c = mcnt % RD;
      s = (mcnt / RD) % 4;
      if (c >= BC && sh_en[s]) begin
        exp_an  = 4'hF ^ (4'h1 << s);
        exp_seg = seg_tab[sh_dig[s]];
        exp_dp  = ~sh_dp[s];
      end else begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      if (mcnt % FRAME == 0) begin
        sh_en[0] = bus.digit0_en_i; sh_en[1] = bus.digit1_en_i;
        sh_en[2] = bus.digit2_en_i; sh_en[3] = bus.digit3_en_i;
        sh_dig[0] = bus.digit0_i; sh_dig[1] = bus.digit1_i;
        sh_dig[2] = bus.digit2_i; sh_dig[3] = bus.digit3_i;
        for (int k = 0; k < 4; k++) sh_dp[k] = bus.dp_i[k];
      end
      mcnt++;
      exp_fr = ((mcnt % FRAME) == 0);
    end
    exp_valid = 1'b1;
  endtask

  task automatic run(input int id, input int ncycles);
    scen = id;
    rst_left = 3;
    repeat (ncycles + 3) tick();
  endtask

  initial begin
    set_inputs(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    run(1, 2 * FRAME);
    run(2, 2 * FRAME);
    check_eq("disabled_digit_no_anode_d", anode_d_seen, 0);
    run(3, 48);
    run(4, 2 * FRAME);
    run(6, 2 * FRAME);
    check_eq("midrst_injected", scen6_done, 1'b1);
    run(5, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
